// File: rtl/at_cmd_pkg.sv
// Shared types and constants for the AT command sender: FSM states, the
// response match characters and the fixed command string table.
package at_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_WAIT_TX,
        ST_WAIT_RESP,
        ST_DONE
    } state_t;

    localparam int CMD_COUNT = 4;
    localparam int CMD_IDX_W = 2;
    localparam int STR_MAX   = 32;
    localparam int STR_LEN_W = 6;

    localparam logic [7:0] ASCII_O = 8'h4F;
    localparam logic [7:0] ASCII_K = 8'h4B;

    typedef logic [0:STR_MAX-1][7:0] cmd_str_t;

    // Strings are left-aligned; trailing bytes past the length are padding.
    localparam cmd_str_t CMD_STR [CMD_COUNT] = '{
        {"AT\015\012",                {28{8'h00}}},
        {"AT+CWMODE=1\015\012",       {19{8'h00}}},
        {"AT+CIPMUX=0\015\012",       {19{8'h00}}},
        {"AT+CIPSERVER=1,80\015\012", {13{8'h00}}}
    };

    localparam logic [STR_LEN_W-1:0] CMD_LEN [CMD_COUNT] = '{
        6'd4, 6'd13, 6'd13, 6'd19
    };

endpackage

// File: rtl/at_cmd_rom.sv
// Combinational command string lookup: (command index, byte position) to
// the byte at that position plus the string length.
module at_cmd_rom
    import at_cmd_pkg::*;
#(
    parameter int LEN_W = 6
) (
    input  logic [CMD_IDX_W-1:0] i_index,
    input  logic [LEN_W-1:0]     i_pos,
    output logic [7:0]           o_byte,
    output logic [LEN_W-1:0]     o_len
);

    always_comb begin
        o_byte = 8'h00;
        for (int k = 0; k < STR_MAX; k++) begin
            if (i_pos == LEN_W'(k)) begin
                o_byte = CMD_STR[i_index][k];
            end
        end
        o_len = LEN_W'(CMD_LEN[i_index]);
    end

endmodule

// File: rtl/at_command_sender.sv
// Streams a ROM command string to the UART on a start edge, then waits for
// an "OK" reply or a timeout before reporting ready again.
module at_command_sender
    import at_cmd_pkg::*;
#(
    parameter int MAX_LEN      = 32,
    parameter int RESP_TIMEOUT = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] command,
    input  logic       start,
    output logic       ready_command,
    output logic       cmd_error,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_valid
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMR_W = $clog2(RESP_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(RESP_TIMEOUT - 1);
    localparam logic [2:0]       CMD_LAST = 3'(CMD_COUNT - 1);

    state_t            r_state;
    logic              r_start_q;
    logic [2:0]        r_cmd;
    logic [LEN_W-1:0]  r_byte_idx;
    logic [LEN_W-1:0]  r_len;
    logic [TMR_W-1:0]  r_timer;
    logic              r_skip;
    logic              r_armed;
    logic              r_ok_seen;

    logic              w_trigger;
    logic [7:0]        w_rom_byte;
    logic [LEN_W-1:0]  w_rom_len;
    logic [LEN_W-1:0]  w_next_idx;
    logic              w_match_en;
    logic              w_k_hit;
    logic              w_ok_now;

    at_cmd_rom #(.LEN_W(LEN_W)) u_rom (
        .i_index (r_cmd[CMD_IDX_W-1:0]),
        .i_pos   (r_byte_idx),
        .o_byte  (w_rom_byte),
        .o_len   (w_rom_len)
    );

    assign w_trigger  = start & ~r_start_q;
    assign w_next_idx = r_byte_idx + LEN_W'(1);
    assign w_match_en = (r_state == ST_LOAD) || (r_state == ST_SEND) ||
                        (r_state == ST_WAIT_TX) || (r_state == ST_WAIT_RESP);
    // A 'K' completing "OK" this cycle counts even before the sticky flag updates.
    assign w_k_hit    = w_match_en & rx_valid & r_armed & (rx_data == ASCII_K);
    assign w_ok_now   = r_ok_seen | w_k_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_armed   <= 1'b0;
            r_ok_seen <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            r_armed   <= 1'b0;
            r_ok_seen <= 1'b0;
        end else if (w_match_en && rx_valid) begin
            if (rx_data == ASCII_O) begin
                r_armed <= 1'b1;
            end else begin
                r_armed <= 1'b0;
                if (w_k_hit) begin
                    r_ok_seen <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_start_q     <= 1'b1;
            r_cmd         <= 3'd0;
            r_byte_idx    <= '0;
            r_len         <= '0;
            r_timer       <= '0;
            r_skip        <= 1'b0;
            ready_command <= 1'b1;
            cmd_error     <= 1'b0;
            tx_data       <= 8'h00;
            tx_start      <= 1'b0;
        end else begin
            r_start_q <= start;
            tx_start  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_cmd         <= command;
                        cmd_error     <= 1'b0;
                        ready_command <= 1'b0;
                        r_state       <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (r_cmd > CMD_LAST) begin
                        cmd_error <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_byte_idx <= '0;
                        r_len      <= w_rom_len;
                        r_timer    <= '0;
                        r_state    <= (w_rom_len == '0) ? ST_WAIT_RESP : ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (!tx_busy) begin
                        tx_data  <= w_rom_byte;
                        tx_start <= 1'b1;
                        r_skip   <= 1'b1;
                        r_state  <= ST_WAIT_TX;
                    end
                end
                ST_WAIT_TX: begin
                    // The UART raises busy one cycle after the strobe.
                    if (r_skip) begin
                        r_skip <= 1'b0;
                    end else if (!tx_busy) begin
                        r_byte_idx <= w_next_idx;
                        if (w_next_idx == r_len) begin
                            r_timer <= '0;
                            r_state <= ST_WAIT_RESP;
                        end else begin
                            r_state <= ST_SEND;
                        end
                    end
                end
                ST_WAIT_RESP: begin
                    if (w_ok_now) begin
                        cmd_error <= 1'b0;
                        r_state   <= ST_DONE;
                    end else if (r_timer == TMR_LAST) begin
                        cmd_error <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                ST_DONE: begin
                    ready_command <= 1'b1;
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_at_command_sender.sv
// Randomised self-checking bench for at_command_sender with a behavioural
// UART model and a string-level reference for bytes sent and reply outcome.
module tb_at_command_sender;

    localparam int RESP_TIMEOUT = 100;
    localparam int BUSY_CYCLES  = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] command = 3'd0;
    logic       start = 1'b0;
    logic       ready_command;
    logic       cmd_error;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int viol     = 0;
    int busy_cnt = 0;
    int last_fall = 0;
    int ready_cyc = 0;
    bit prev_start = 1'b0;
    logic [7:0] tx_q[$];

    string exp_str[4] = '{"AT\015\012", "AT+CWMODE=1\015\012",
                          "AT+CIPMUX=0\015\012", "AT+CIPSERVER=1,80\015\012"};
    string pool[6] = '{"OK\015\012", "XOOK", "O\012K", "", "KOOXK", "OOK"};

    at_command_sender #(.MAX_LEN(32), .RESP_TIMEOUT(RESP_TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .command       (command),
        .start         (start),
        .ready_command (ready_command),
        .cmd_error     (cmd_error),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // UART transmitter model plus protocol monitors, evaluated mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            busy_cnt   = 0;
            tx_busy    = 1'b0;
            prev_start = 1'b0;
        end else begin
            if (tx_start && tx_busy) viol++;
            if (tx_start && prev_start) viol++;
            prev_start = tx_start;
            if (tx_start) begin
                tx_q.push_back(tx_data);
                busy_cnt = BUSY_CYCLES;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            if (tx_busy && busy_cnt == 0) last_fall = cyc;
            tx_busy = (busy_cnt > 0);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit has_ok(input string s);
        for (int i = 0; i + 1 < s.len(); i++)
            if (s[i] == 8'h4F && s[i+1] == 8'h4B) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int first_diff(input int c);
        int n;
        n = (tx_q.size() > exp_str[c].len()) ? tx_q.size() : exp_str[c].len();
        for (int i = 0; i < n; i++)
            if (i >= tx_q.size() || i >= exp_str[c].len() || tx_q[i] != exp_str[c][i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; command = 3'd0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int cmd);
        @(negedge clk);
        command = 3'(cmd);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_reply(input string s);
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            rx_data = s[i];
            rx_valid = 1'b1;
            @(negedge clk);
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic wait_tx(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (tx_q.size() == n && !tx_busy) begin ok = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (ready_command === 1'b1) begin ok = 1'b1; ready_cyc = cyc; break; end
            @(negedge clk);
        end
    endtask

    task automatic run_cmd(input int cmd, input string reply, output bit saw_low, output bit done);
        bit ok_tx;
        tx_q.delete();
        pulse_start(cmd);
        saw_low = (ready_command === 1'b0);
        if (cmd < 4) begin
            wait_tx(exp_str[cmd].len(), ok_tx);
            if (ok_tx) send_reply(reply);
        end
        wait_ready(done);
    endtask

    task automatic test_reset();
        checks++; if (ready_command !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", ready_command); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b expected 0", cmd_error); end
        checks++; if (tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b expected 0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    endtask

    task automatic test_start_at_reset();
        bit low, done;
        int d;
        tx_q.delete();
        rst = 1'b1; start = 1'b1; command = 3'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (ready_command !== 1'b1) begin failures++; $display("FAIL held_start_ready: got %b expected 1", ready_command); end
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL held_start_bytes: got %0d expected 0", tx_q.size()); end
        start = 1'b0;
        @(negedge clk);
        run_cmd(0, "OK\015\012", low, done);
        d = first_diff(0);
        checks++; if (!done) begin failures++; $display("FAIL after_reset_done: got 0 expected 1"); end
        checks++; if (d != -1) begin failures++; $display("FAIL after_reset_bytes: first diff at %0d expected none", d); end
    endtask

    task automatic test_cmd0_ok();
        bit low, done;
        int d;
        run_cmd(0, "OK\015\012", low, done);
        d = first_diff(0);
        checks++; if (!low) begin failures++; $display("FAIL cmd0_busy: ready got %b expected 0", ready_command); end
        checks++; if (!done) begin failures++; $display("FAIL cmd0_done: got 0 expected 1"); end
        checks++; if (d != -1) begin failures++; $display("FAIL cmd0_bytes: first diff at %0d of %0d bytes", d, tx_q.size()); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL cmd0_error: got %b expected 0", cmd_error); end
    endtask

    // Latency from the UART dropping busy: one cycle to notice, RESP_TIMEOUT
    // cycles of waiting, then one completion cycle before ready rises.
    task automatic test_timeout();
        bit low, done;
        int d;
        run_cmd(2, "", low, done);
        d = first_diff(2);
        checks++; if (!done) begin failures++; $display("FAIL timeout_done: got 0 expected 1"); end
        checks++; if (d != -1) begin failures++; $display("FAIL timeout_bytes: first diff at %0d", d); end
        checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL timeout_error: got %b expected 1", cmd_error); end
        checks++; if (ready_cyc - last_fall != RESP_TIMEOUT + 2) begin failures++;
            $display("FAIL timeout_latency: got %0d expected %0d", ready_cyc - last_fall, RESP_TIMEOUT + 2); end
    endtask

    task automatic test_invalid();
        int lowcnt = 0;
        tx_q.delete();
        pulse_start(5);
        for (int i = 0; i < 50 && ready_command === 1'b0; i++) begin
            lowcnt++;
            @(negedge clk);
        end
        repeat (5) @(negedge clk);
        checks++; if (lowcnt != 2) begin failures++; $display("FAIL invalid_low_cycles: got %0d expected 2", lowcnt); end
        checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL invalid_error: got %b expected 1", cmd_error); end
        checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL invalid_bytes: got %0d expected 0", tx_q.size()); end
    endtask

    task automatic test_matcher();
        bit low, done;
        run_cmd(0, "XOOK", low, done);
        checks++; if (!done) begin failures++; $display("FAIL xook_done: got 0 expected 1"); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL xook_error: got %b expected 0", cmd_error); end
        run_cmd(3, "O\012K", low, done);
        checks++; if (!done) begin failures++; $display("FAIL split_ok_done: got 0 expected 1"); end
        checks++; if (cmd_error !== 1'b1) begin failures++; $display("FAIL split_ok_error: got %b expected 1", cmd_error); end
    endtask

    task automatic test_ignored_edge();
        bit ok, done;
        int d;
        tx_q.delete();
        pulse_start(1);
        for (int i = 0; i < 500 && tx_q.size() < 2; i++) @(negedge clk);
        pulse_start(0);
        wait_tx(13, ok);
        if (ok) send_reply("OK");
        wait_ready(done);
        d = first_diff(1);
        checks++; if (!done) begin failures++; $display("FAIL mid_edge_done: got 0 expected 1"); end
        checks++; if (d != -1) begin failures++; $display("FAIL mid_edge_bytes: first diff at %0d of %0d bytes", d, tx_q.size()); end
        checks++; if (cmd_error !== 1'b0) begin failures++; $display("FAIL mid_edge_error: got %b expected 0", cmd_error); end
        repeat (30) @(negedge clk);
        checks++; if (ready_command !== 1'b1 || tx_q.size() != 13) begin failures++;
            $display("FAIL mid_edge_queued: ready %b bytes %0d expected ready 1 bytes 13", ready_command, tx_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit low, done, hit;
        int d;
        tx_q.delete();
        pulse_start(3);
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (tx_q.size() == 3) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!hit) begin failures++; $display("FAIL abort_reach_byte3: got %0d bytes expected 3", tx_q.size()); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (ready_command !== 1'b1 || tx_start !== 1'b0) begin failures++;
            $display("FAIL abort_outputs: ready %b tx_start %b expected 1 0", ready_command, tx_start); end
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        checks++; if (tx_q.size() != 3) begin failures++; $display("FAIL abort_no_more_tx: got %0d expected 3", tx_q.size()); end
        run_cmd(0, "OK\015\012", low, done);
        d = first_diff(0);
        checks++; if (!done || cmd_error !== 1'b0) begin failures++;
            $display("FAIL abort_recover: done %b error %b expected 1 0", done, cmd_error); end
        checks++; if (d != -1) begin failures++; $display("FAIL abort_recover_bytes: first diff at %0d", d); end
    endtask

    task automatic test_random();
        bit low, done, exp_err;
        int c, d;
        string r;
        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(0, 7);
            if ($urandom_range(0, 3) == 0) begin
                r = "";
                for (int k = 0; k < 4; k++) begin
                    case ($urandom_range(0, 2))
                        0: r = {r, "O"};
                        1: r = {r, "K"};
                        default: r = {r, "X"};
                    endcase
                end
            end else begin
                r = pool[$urandom_range(0, 5)];
            end
            exp_err = (c > 3) || !has_ok(r);
            run_cmd(c, r, low, done);
            checks++; if (!done || !low) begin failures++; $display("FAIL rand%0d_handshake: cmd %0d low %b done %b expected 1 1", it, c, low, done); end
            checks++; if (cmd_error !== exp_err) begin failures++; $display("FAIL rand%0d_error: cmd %0d got %b expected %b", it, c, cmd_error, exp_err); end
            if (c < 4) begin
                d = first_diff(c);
                checks++; if (d != -1) begin failures++; $display("FAIL rand%0d_bytes: cmd %0d first diff at %0d", it, c, d); end
            end else begin
                checks++; if (tx_q.size() != 0) begin failures++; $display("FAIL rand%0d_bytes: cmd %0d got %0d bytes expected 0", it, c, tx_q.size()); end
            end
        end
    endtask

    task automatic test_protocol();
        checks++; if (viol != 0) begin failures++; $display("FAIL tx_start_protocol: got %0d violations expected 0", viol); end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_start_at_reset();
        test_cmd0_ok();
        test_timeout();
        test_invalid();
        test_matcher();
        test_ignored_edge();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
